// File: rtl/entropy_collector.sv
// entropy_collector: synchronizes a metastable source, samples it on a divided
// strobe, applies a repetition-count health test and a von Neumann corrector,
// and packs corrected bits into WIDTH-bit words behind a one-word output buffer.
//
// Output handshake: data/valid form a standard valid/ready pair. Once valid is
// high, data stays stable until valid && ready is seen on a rising edge; only
// a health failure or reset may withdraw a word. A transfer and a reload on the
// same edge keep valid high with the new word.
module entropy_collector #(
    parameter int WIDTH      = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             metastable,
    input  logic             enable,
    input  logic             clear_fail,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } pair_state_e;

    // Synchronizer: sync_q[0] is the first stage, sync_q[1] is the raw sample.
    logic [1:0] sync_q;
    logic       raw;

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       rep_cnt_q, rep_cnt_d;
    logic             last_raw_q, last_raw_d;
    logic             first_bit_q, first_bit_d;
    pair_state_e      state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fail_q, fail_d;

    logic       strobe;
    logic [7:0] rep_next;
    logic       emit;
    logic       fail_detect;
    logic       load;

    assign raw         = sync_q[1];
    assign data        = data_q;
    assign valid       = valid_q;
    assign health_fail = fail_q;

    // Two-flop synchronizer with nothing in front of the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], metastable};
        end
    end

    // Next-state logic for divider, health test, pair FSM, accumulator and output buffer.
    always_comb begin
        div_d       = div_q;
        rep_cnt_d   = rep_cnt_q;
        last_raw_d  = last_raw_q;
        first_bit_d = first_bit_q;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        fail_d      = fail_q;
        emit        = 1'b0;

        strobe = enable && (div_q == DIV_LAST);

        // Saturate so a long stuck run cannot wrap back below the limit.
        if (raw == last_raw_q) begin
            rep_next = (rep_cnt_q == 8'hFF) ? rep_cnt_q : rep_cnt_q + 8'd1;
        end else begin
            rep_next = 8'd1;
        end

        fail_detect = strobe && (rep_next >= REP_MAX);

        // The divider only runs while enabled; everything sample-driven freezes with it.
        if (enable) begin
            div_d = strobe ? '0 : div_q + DIV_W'(1);
        end

        if (strobe) begin
            rep_cnt_d  = rep_next;
            last_raw_d = raw;
            case (state_q)
                ST_FIRST: begin
                    first_bit_d = raw;
                    state_d     = ST_SECOND;
                end
                default: begin
                    emit    = (raw != first_bit_q);
                    state_d = ST_FIRST;
                end
            endcase
        end

        // Consumer handshake drains the output register.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        // Reload from a full accumulator when the output is free or freeing this edge.
        load = (cnt_q == CNT_FULL) && (!valid_q || ready) && !clear_fail && !fail_detect;
        if (load) begin
            data_d  = acc_q;
            valid_d = 1'b1;
            cnt_d   = '0;
        end

        // Corrected bits are taken only while healthy and while the accumulator has room.
        if (emit && !fail_q && (cnt_q != CNT_FULL) && !clear_fail && !fail_detect) begin
            acc_d = {acc_q[WIDTH-2:0], first_bit_q};
            cnt_d = cnt_q + CNT_W'(1);
        end

        // clear_fail takes priority over a failure detected on the same edge.
        if (clear_fail) begin
            fail_d    = 1'b0;
            rep_cnt_d = 8'd0;
            state_d   = ST_FIRST;
            cnt_d     = '0;
        end else if (fail_detect) begin
            fail_d  = 1'b1;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_FIRST;
        end
    end

    // State registers, including the pair FSM and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            rep_cnt_q   <= 8'd0;
            last_raw_q  <= 1'b0;
            first_bit_q <= 1'b0;
            state_q     <= ST_FIRST;
            acc_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            rep_cnt_q   <= rep_cnt_d;
            last_raw_q  <= last_raw_d;
            first_bit_q <= first_bit_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            fail_q      <= fail_d;
        end
    end

endmodule
